// File: rtl/risc_phase_ctrl.sv
// risc_phase_ctrl: eight-phase sequence controller for the RISC-Y datapath.
// It steps a 3-bit phase counter on each enabled clock. It decodes phase,
// opcode, the accumulator zero flag and the halt state into the datapath
// load/enable strobes. A HLT instruction at phase 4 freezes sequencing until
// the next reset.
//
// Ports:
//   CLK     in   system clock, rising edge
//   RST     in   synchronous active-high reset
//   ENA     in   advance enable; phase and halt state hold while low
//   OPCODE  in   opcode field from the IR output
//   ZERO    in   accumulator-is-zero flag
//   PHASE   out  current phase (registered)
//   HALTED  out  sticky halt state (registered)
//   SEL     out  address mux select: 1 = PC, 0 = IR operand
//   RD, WR  out  memory read / write
//   LD_IR, LD_AC  out  IR / AC register enables
//   LD_PC, INC_PC out  PC load (jump) / PC increment
//   DATA_E  out  AC-to-data-bus tristate enable
//   HALT    out  halt indication
// Strobe outputs are combinational decodes of the registered state.
module risc_phase_ctrl #(
    parameter int unsigned OP_W = 3,
    parameter int unsigned PH_W = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ENA,
    input  logic [OP_W-1:0] OPCODE,
    input  logic            ZERO,
    output logic [PH_W-1:0] PHASE,
    output logic            HALTED,
    output logic            SEL,
    output logic            RD,
    output logic            WR,
    output logic            LD_IR,
    output logic            LD_AC,
    output logic            LD_PC,
    output logic            INC_PC,
    output logic            DATA_E,
    output logic            HALT
);

    localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
    localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

    localparam logic [PH_W-1:0] PH_INST_ADDR  = PH_W'(0);
    localparam logic [PH_W-1:0] PH_INST_FETCH = PH_W'(1);
    localparam logic [PH_W-1:0] PH_INST_LOAD  = PH_W'(2);
    localparam logic [PH_W-1:0] PH_IDLE       = PH_W'(3);
    localparam logic [PH_W-1:0] PH_OP_ADDR    = PH_W'(4);
    localparam logic [PH_W-1:0] PH_OP_FETCH   = PH_W'(5);
    localparam logic [PH_W-1:0] PH_ALU_OP     = PH_W'(6);
    localparam logic [PH_W-1:0] PH_STORE      = PH_W'(7);

    logic [PH_W-1:0] phase_nxt;
    logic            halted_nxt;
    logic [PH_W-1:0] dec_phase;
    logic            dec_halted;
    logic            is_aluop;
    logic            is_hlt;
    logic            is_skz;
    logic            is_sto;
    logic            is_jmp;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            PHASE  <= '0;
            HALTED <= 1'b0;
        end else begin
            PHASE  <= phase_nxt;
            HALTED <= halted_nxt;
        end
    end

    // Next state: advance on enable unless halted; HLT at phase 4 parks here
    always_comb begin
        phase_nxt  = PHASE;
        halted_nxt = HALTED;
        if (ENA && !HALTED) begin
            if (PHASE == PH_OP_ADDR && OPCODE == OP_HLT) begin
                halted_nxt = 1'b1;
            end else begin
                phase_nxt = PHASE + PH_W'(1);
            end
        end
    end

    assign is_hlt   = (OPCODE == OP_HLT);
    assign is_skz   = (OPCODE == OP_SKZ);
    assign is_sto   = (OPCODE == OP_STO);
    assign is_jmp   = (OPCODE == OP_JMP);
    assign is_aluop = (OPCODE == OP_ADD) || (OPCODE == OP_AND) ||
                      (OPCODE == OP_XOR) || (OPCODE == OP_LDA);

    // While reset is held, decode as phase 0 even before the register clears
    assign dec_phase  = RST ? PH_INST_ADDR : PHASE;
    assign dec_halted = RST ? 1'b0 : HALTED;

    // Strobe decode; state-changing strobes are masked when stalled
    always_comb begin
        SEL    = 1'b0;
        RD     = 1'b0;
        WR     = 1'b0;
        LD_IR  = 1'b0;
        LD_AC  = 1'b0;
        LD_PC  = 1'b0;
        INC_PC = 1'b0;
        DATA_E = 1'b0;
        HALT   = 1'b0;
        case (dec_phase)
            PH_INST_ADDR: begin
                SEL = 1'b1;
            end
            PH_INST_FETCH: begin
                SEL = 1'b1;
                RD  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                SEL   = 1'b1;
                RD    = 1'b1;
                LD_IR = 1'b1;
            end
            PH_OP_ADDR: begin
                HALT   = is_hlt || dec_halted;
                // PC bumps once on the edge entering halt, never while parked
                INC_PC = !dec_halted;
            end
            PH_OP_FETCH: begin
                RD = is_aluop;
            end
            PH_ALU_OP: begin
                RD     = is_aluop;
                INC_PC = is_skz && ZERO;
                LD_PC  = is_jmp;
                DATA_E = is_sto;
            end
            PH_STORE: begin
                RD     = is_aluop;
                LD_AC  = is_aluop;
                LD_PC  = is_jmp;
                INC_PC = is_jmp;
                DATA_E = is_sto;
                WR     = is_sto;
            end
            default: begin
                SEL = 1'b0;
            end
        endcase
        if (!ENA) begin
            LD_IR  = 1'b0;
            LD_AC  = 1'b0;
            LD_PC  = 1'b0;
            INC_PC = 1'b0;
            WR     = 1'b0;
        end
    end

endmodule

// File: tb/tb_risc_phase_ctrl.sv
// Directed bench for risc_phase_ctrl: per-phase strobe tables for each
// opcode class, halt entry and hold, stall and mid-instruction reset.
module tb_risc_phase_ctrl;

    logic       CLK;
    logic       RST;
    logic       ENA;
    logic [2:0] OPCODE;
    logic       ZERO;
    logic [2:0] PHASE;
    logic       HALTED;
    logic       SEL, RD, WR, LD_IR, LD_AC, LD_PC, INC_PC, DATA_E, HALT;

    int total = 0;
    int bad   = 0;

    // Strobe vector bit order: SEL RD WR LD_IR LD_AC LD_PC INC_PC DATA_E HALT
    logic [8:0] strb;
    assign strb = {SEL, RD, WR, LD_IR, LD_AC, LD_PC, INC_PC, DATA_E, HALT};

    typedef logic [8:0] vtab_t [8];

    localparam logic [8:0] S_P0  = 9'b1_0_0_0_0_0_0_0_0;
    localparam logic [8:0] S_P1  = 9'b1_1_0_0_0_0_0_0_0;
    localparam logic [8:0] S_P2  = 9'b1_1_0_1_0_0_0_0_0;
    localparam logic [8:0] S_P4  = 9'b0_0_0_0_0_0_1_0_0;
    localparam logic [8:0] S_NONE = 9'b0_0_0_0_0_0_0_0_0;

    localparam vtab_t ADD_V = '{S_P0, S_P1, S_P2, S_P2, S_P4,
                                9'b0_1_0_0_0_0_0_0_0,
                                9'b0_1_0_0_0_0_0_0_0,
                                9'b0_1_0_0_1_0_0_0_0};
    localparam vtab_t STO_V = '{S_P0, S_P1, S_P2, S_P2, S_P4, S_NONE,
                                9'b0_0_0_0_0_0_0_1_0,
                                9'b0_0_1_0_0_0_0_1_0};
    localparam vtab_t SKZ1_V = '{S_P0, S_P1, S_P2, S_P2, S_P4, S_NONE,
                                 9'b0_0_0_0_0_0_1_0_0,
                                 S_NONE};
    localparam vtab_t SKZ0_V = '{S_P0, S_P1, S_P2, S_P2, S_P4, S_NONE,
                                 S_NONE, S_NONE};
    localparam vtab_t JMP_V = '{S_P0, S_P1, S_P2, S_P2, S_P4, S_NONE,
                                9'b0_0_0_0_0_1_0_0_0,
                                9'b0_0_0_0_0_1_1_0_0};

    risc_phase_ctrl #(.OP_W(3), .PH_W(3)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .ENA    (ENA),
        .OPCODE (OPCODE),
        .ZERO   (ZERO),
        .PHASE  (PHASE),
        .HALTED (HALTED),
        .SEL    (SEL),
        .RD     (RD),
        .WR     (WR),
        .LD_IR  (LD_IR),
        .LD_AC  (LD_AC),
        .LD_PC  (LD_PC),
        .INC_PC (INC_PC),
        .DATA_E (DATA_E),
        .HALT   (HALT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Check phase and strobes in the current cycle, then clock once
    task automatic chk_cycle(input string nm, input logic [2:0] ph, input logic [8:0] sv);
        #1;
        chk($sformatf("%s_phase%0d", nm, ph), 32'(PHASE), 32'(ph));
        chk($sformatf("%s_strb%0d", nm, ph), 32'(strb), 32'(sv));
        tick();
    endtask

    task automatic run_instr(input string nm, input logic [2:0] op, input logic z, input vtab_t ev);
        OPCODE = op;
        ZERO   = z;
        ENA    = 1'b1;
        for (int p = 0; p < 8; p++) begin
            chk_cycle(nm, 3'(p), ev[p]);
        end
        chk({nm, "_wrap"}, 32'(PHASE), 32'd0);
    endtask

    initial begin
        RST    = 1'b1;
        ENA    = 1'b0;
        OPCODE = 3'd2;
        ZERO   = 1'b0;
        tick();
        tick();
        chk("rst_phase", 32'(PHASE), 32'd0);
        chk("rst_halted", 32'(HALTED), 32'd0);
        chk("rst_strb", 32'(strb), 32'(S_P0));

        RST = 1'b0;
        run_instr("add",  3'd2, 1'b0, ADD_V);
        run_instr("sto",  3'd6, 1'b0, STO_V);
        run_instr("skz1", 3'd1, 1'b1, SKZ1_V);
        run_instr("skz0", 3'd1, 1'b0, SKZ0_V);
        run_instr("jmp",  3'd7, 1'b0, JMP_V);

        // HLT: fetch phases, then park at phase 4
        OPCODE = 3'd0;
        ZERO   = 1'b0;
        ENA    = 1'b1;
        chk_cycle("hlt", 3'd0, S_P0);
        chk_cycle("hlt", 3'd1, S_P1);
        chk_cycle("hlt", 3'd2, S_P2);
        chk_cycle("hlt", 3'd3, S_P2);
        chk_cycle("hlt", 3'd4, 9'b0_0_0_0_0_0_1_0_1);
        chk("hlt_halted", 32'(HALTED), 32'd1);
        chk("hlt_phase", 32'(PHASE), 32'd4);
        for (int i = 0; i < 20; i++) begin
            ENA    = (i % 3 != 2);
            OPCODE = (i < 10) ? 3'd0 : 3'd2;
            #1;
            chk($sformatf("hold_phase_%0d", i), 32'(PHASE), 32'd4);
            chk($sformatf("hold_inc_%0d", i), 32'(INC_PC), 32'd0);
            chk($sformatf("hold_halt_%0d", i), 32'(HALT), 32'd1);
            tick();
        end
        chk("hold_halted", 32'(HALTED), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("unhalt_phase", 32'(PHASE), 32'd0);
        chk("unhalt_halted", 32'(HALTED), 32'd0);

        // Stall in phase 2
        OPCODE = 3'd2;
        ENA    = 1'b1;
        chk_cycle("stl", 3'd0, S_P0);
        chk_cycle("stl", 3'd1, S_P1);
        ENA = 1'b0;
        chk_cycle("stl_a", 3'd2, 9'b1_1_0_0_0_0_0_0_0);
        chk_cycle("stl_b", 3'd2, 9'b1_1_0_0_0_0_0_0_0);
        ENA = 1'b1;
        chk_cycle("stl_go", 3'd2, S_P2);
        chk_cycle("stl", 3'd3, S_P2);
        chk_cycle("stl", 3'd4, S_P4);
        // Reset mid-instruction at phase 5
        chk("mid_phase5", 32'(PHASE), 32'd5);
        RST = 1'b1;
        #1;
        chk("mid_rst_strb", 32'(strb), 32'(S_P0));
        tick();
        RST = 1'b0;
        chk("mid_rst_phase", 32'(PHASE), 32'd0);
        tick();
        chk("mid_after_phase", 32'(PHASE), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
